// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result-select codes, load types and default widths.
package wb_pkg;
  localparam int WB_DATA_W     = 32;
  localparam int WB_REG_ADDR_W = 5;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;
  localparam logic [1:0] WB_SEL_RSVD = 2'b11;

  localparam logic [2:0] LT_LB  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LW  = 3'd2;
  localparam logic [2:0] LT_LBU = 3'd4;
  localparam logic [2:0] LT_LHU = 3'd5;
endpackage

// File: rtl/load_extend.sv
// Combinational load alignment: picks the byte/half from the raw word, extends it, flags misalignment.
module load_extend
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [2:0]        load_type,
  input  logic [1:0]        byte_off,
  output logic [DATA_W-1:0] data,
  output logic              misaligned
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  function automatic logic [DATA_W-1:0] ext_byte(input logic signed [7:0] b, input logic sgn);
    return sgn ? DATA_W'(b) : DATA_W'($unsigned(b));
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic signed [15:0] h, input logic sgn);
    return sgn ? DATA_W'(h) : DATA_W'($unsigned(h));
  endfunction

  assign byte_s = raw[8*byte_off +: 8];
  assign half_s = raw[16*byte_off[1] +: 16];

  always_comb begin
    data       = '0;
    misaligned = 1'b0;
    unique case (load_type)
      LT_LB:   data = ext_byte(byte_s, 1'b1);
      LT_LBU:  data = ext_byte(byte_s, 1'b0);
      LT_LH: begin
        data       = ext_half(half_s, 1'b1);
        misaligned = byte_off[0];
      end
      LT_LHU: begin
        data       = ext_half(half_s, 1'b0);
        misaligned = byte_off[0];
      end
      LT_LW: begin
        data       = raw;
        misaligned = (byte_off != 2'b00);
      end
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB register, result select, register-file write port, forwarding tap
// and retired-instruction counter.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int REG_ADDR_W = WB_REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_reg_write,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [1:0]            in_wb_sel,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic [DATA_W-1:0]     in_pc_plus4,
  input  logic [2:0]            in_load_type,
  input  logic [1:0]            in_byte_off,
  output logic [REG_ADDR_W-1:0] writeReg,
  output logic                  writeEnable,
  output logic [DATA_W-1:0]     writeData,
  output logic                  wb_valid,
  output logic                  fwd_en,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]     fwd_data,
  output logic                  misalign_err,
  output logic [CNT_W-1:0]      retire_count
);

  logic                  vld_p0;
  logic                  reg_write_p0;
  logic [REG_ADDR_W-1:0] rd_p0;
  logic [1:0]            wb_sel_p0;
  logic [DATA_W-1:0]     alu_p0;
  logic [DATA_W-1:0]     mem_p0;
  logic [DATA_W-1:0]     pc4_p0;
  logic [2:0]            load_type_p0;
  logic [1:0]            byte_off_p0;
  logic [CNT_W-1:0]      retire_cnt;
  logic [DATA_W-1:0]     load_data;
  logic                  load_misaligned;

  // MEM/WB boundary: reset beats flush, flush beats stall, otherwise capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p0       <= 1'b0;
      reg_write_p0 <= 1'b0;
      rd_p0        <= '0;
      wb_sel_p0    <= WB_SEL_ALU;
      alu_p0       <= '0;
      mem_p0       <= '0;
      pc4_p0       <= '0;
      load_type_p0 <= LT_LB;
      byte_off_p0  <= '0;
      retire_cnt   <= '0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
    end else if (!stall) begin
      vld_p0       <= in_valid;
      reg_write_p0 <= in_reg_write;
      rd_p0        <= in_rd;
      wb_sel_p0    <= in_wb_sel;
      alu_p0       <= in_alu_result;
      mem_p0       <= in_mem_data;
      pc4_p0       <= in_pc_plus4;
      load_type_p0 <= in_load_type;
      byte_off_p0  <= in_byte_off;
      if (in_valid) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .raw        (mem_p0),
    .load_type  (load_type_p0),
    .byte_off   (byte_off_p0),
    .data       (load_data),
    .misaligned (load_misaligned)
  );

  always_comb begin
    writeData = '0;
    unique case (wb_sel_p0)
      WB_SEL_ALU:  writeData = alu_p0;
      WB_SEL_MEM:  writeData = load_data;
      WB_SEL_LINK: writeData = pc4_p0;
      default:     writeData = '0;
    endcase
  end

  assign misalign_err = vld_p0 & (wb_sel_p0 == WB_SEL_MEM) & load_misaligned;
  assign writeEnable  = vld_p0 & reg_write_p0 & (rd_p0 != '0) & ~misalign_err
                        & (wb_sel_p0 != WB_SEL_RSVD);
  assign writeReg     = rd_p0;
  assign wb_valid     = vld_p0;
  assign fwd_en       = writeEnable;
  assign fwd_rd       = writeReg;
  assign fwd_data     = writeData;
  assign retire_count = retire_cnt;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a 32-bit counter instance plus a 4-bit counter instance for wrap.
module tb_writeback_stage;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush, in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel, in_byte_off;
  logic [31:0] in_alu_result, in_mem_data, in_pc_plus4;
  logic [2:0]  in_load_type;

  logic [4:0]  writeReg, fwd_rd;
  logic        writeEnable, wb_valid, fwd_en, misalign_err;
  logic [31:0] writeData, fwd_data, retire_count;

  logic [4:0]  t4_writeReg, t4_fwd_rd;
  logic        t4_writeEnable, t4_wb_valid, t4_fwd_en, t4_misalign_err;
  logic [31:0] t4_writeData, t4_fwd_data;
  logic [3:0]  t4_retire_count;

  logic [31:0] rf [32];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .in_pc_plus4(in_pc_plus4),
    .in_load_type(in_load_type), .in_byte_off(in_byte_off),
    .writeReg(writeReg), .writeEnable(writeEnable), .writeData(writeData),
    .wb_valid(wb_valid), .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .misalign_err(misalign_err), .retire_count(retire_count)
  );

  writeback_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .in_pc_plus4(in_pc_plus4),
    .in_load_type(in_load_type), .in_byte_off(in_byte_off),
    .writeReg(t4_writeReg), .writeEnable(t4_writeEnable), .writeData(t4_writeData),
    .wb_valid(t4_wb_valid), .fwd_en(t4_fwd_en), .fwd_rd(t4_fwd_rd), .fwd_data(t4_fwd_data),
    .misalign_err(t4_misalign_err), .retire_count(t4_retire_count)
  );

  // Register file model: commits on the negedge after the WB outputs settle.
  always @(negedge clk) if (writeEnable) rf[writeReg] <= writeData;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc4, input logic [2:0] lt, input logic [1:0] off);
    in_valid = v; in_reg_write = rw; in_rd = rd; in_wb_sel = sel;
    in_alu_result = alu; in_mem_data = mem; in_pc_plus4 = pc4;
    in_load_type = lt; in_byte_off = off;
    if (!reset) exp_cnt = '0;
    else if (!flush && !stall && v) exp_cnt = exp_cnt + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input string tag, input logic [2:0] lt, input logic [1:0] off,
                      input logic [31:0] exp_data);
    drive(1, 1, 5'd9, WB_SEL_MEM, 32'h0, 32'h80FF7F01, 32'h0, lt, off);
    check({tag, "_data"}, writeData, exp_data);
    check({tag, "_we"}, writeEnable, 1);
    check({tag, "_mis"}, misalign_err, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    exp_cnt = '0;
    reset = 1'b0; stall = 1'b0; flush = 1'b0;

    // Reset held two cycles while MEM presents a valid write to r5
    drive(1, 1, 5'd5, WB_SEL_ALU, 32'h12345678, 32'h0, 32'h0, LT_LW, 2'd0);
    check("rst_we", writeEnable, 0);
    check("rst_reg", writeReg, 0);
    check("rst_data", writeData, 0);
    check("rst_vld", wb_valid, 0);
    check("rst_mis", misalign_err, 0);
    check("rst_cnt", retire_count, 0);
    drive(1, 1, 5'd5, WB_SEL_ALU, 32'h12345678, 32'h0, 32'h0, LT_LW, 2'd0);
    check("rst2_cnt", retire_count, 0);
    check("rst2_we", writeEnable, 0);
    reset = 1'b1;

    // ALU write to r7
    drive(1, 1, 5'd7, WB_SEL_ALU, 32'hDEADBEEF, 32'h0, 32'h0, LT_LW, 2'd0);
    check("alu_reg", writeReg, 7);
    check("alu_we", writeEnable, 1);
    check("alu_data", writeData, 32'hDEADBEEF);
    check("alu_fwd_en", fwd_en, 1);
    check("alu_fwd_rd", fwd_rd, 7);
    check("alu_fwd_data", fwd_data, 32'hDEADBEEF);
    check("alu_cnt", retire_count, 1);
    @(negedge clk); #1;
    check("alu_rf7", rf[7], 32'hDEADBEEF);

    // Loads from 0x80FF7F01
    load("lb3", LT_LB, 2'd3, 32'hFFFFFF80);
    load("lbu3", LT_LBU, 2'd3, 32'h00000080);
    load("lh2", LT_LH, 2'd2, 32'hFFFF80FF);
    load("lhu0", LT_LHU, 2'd0, 32'h00007F01);
    load("lw0", LT_LW, 2'd0, 32'h80FF7F01);
    load("lb1", LT_LB, 2'd1, 32'h0000007F);
    drive(1, 1, 5'd9, WB_SEL_MEM, 32'h0, 32'h80FF7F01, 32'h0, LT_LH, 2'd1);
    check("lh1_mis", misalign_err, 1);
    check("lh1_we", writeEnable, 0);
    check("lh1_cnt", retire_count, exp_cnt);
    drive(1, 1, 5'd9, WB_SEL_MEM, 32'h0, 32'h80FF7F01, 32'h0, LT_LW, 2'd2);
    check("lw2_mis", misalign_err, 1);
    check("lw2_we", writeEnable, 0);

    // Boundaries: r0, link, reserved select
    drive(1, 1, 5'd0, WB_SEL_ALU, 32'h11111111, 32'h0, 32'h0, LT_LW, 2'd0);
    check("r0_we", writeEnable, 0);
    drive(1, 1, 5'd31, WB_SEL_LINK, 32'h0, 32'h0, 32'h00000104, LT_LW, 2'd0);
    check("link_data", writeData, 32'h00000104);
    check("link_we", writeEnable, 1);
    check("link_reg", writeReg, 31);
    check("t4_data", t4_writeData, 32'h00000104);
    check("t4_reg", t4_writeReg, 31);
    check("t4_we", t4_writeEnable, 1);
    check("t4_vld", t4_wb_valid, 1);
    check("t4_fwd_en", t4_fwd_en, 1);
    check("t4_fwd_rd", t4_fwd_rd, 31);
    check("t4_fwd_data", t4_fwd_data, 32'h00000104);
    check("t4_mis", t4_misalign_err, 0);
    drive(1, 1, 5'd12, WB_SEL_RSVD, 32'h22222222, 32'h0, 32'h0, LT_LW, 2'd0);
    check("rsvd_we", writeEnable, 0);
    check("rsvd_data", writeData, 0);
    check("rsvd_vld", wb_valid, 1);
    drive(0, 1, 5'd13, WB_SEL_ALU, 32'h33333333, 32'h0, 32'h0, LT_LW, 2'd0);
    check("bubble_we", writeEnable, 0);
    check("bubble_cnt", retire_count, exp_cnt);

    // Stall holds the captured r3 write for three cycles
    drive(1, 1, 5'd3, WB_SEL_ALU, 32'hCAFE0003, 32'h0, 32'h0, LT_LW, 2'd0);
    check("cap3_data", writeData, 32'hCAFE0003);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'd4, WB_SEL_LINK, 32'h0, 32'h0, 32'h99999999, LT_LW, 2'd0);
      check("stall_reg", writeReg, 3);
      check("stall_data", writeData, 32'hCAFE0003);
      check("stall_we", writeEnable, 1);
      check("stall_cnt", retire_count, exp_cnt);
    end
    flush = 1'b1;
    drive(1, 1, 5'd4, WB_SEL_ALU, 32'h44444444, 32'h0, 32'h0, LT_LW, 2'd0);
    check("sf_vld", wb_valid, 0);
    check("sf_we", writeEnable, 0);
    check("sf_cnt", retire_count, exp_cnt);
    stall = 1'b0; flush = 1'b0;

    // Back-to-back writes to r20: each presented, the last lands in the register file
    drive(1, 1, 5'd20, WB_SEL_ALU, 32'hAAAA0001, 32'h0, 32'h0, LT_LW, 2'd0);
    check("b2b1_data", writeData, 32'hAAAA0001);
    drive(1, 1, 5'd20, WB_SEL_ALU, 32'hAAAA0002, 32'h0, 32'h0, LT_LW, 2'd0);
    check("b2b2_data", writeData, 32'hAAAA0002);
    @(negedge clk); #1;
    check("b2b_rf20", rf[20], 32'hAAAA0002);

    // Reset mid-operation discards the pending write
    reset = 1'b0;
    drive(1, 1, 5'd21, WB_SEL_ALU, 32'h55555555, 32'h0, 32'h0, LT_LW, 2'd0);
    check("midrst_we", writeEnable, 0);
    check("midrst_cnt", retire_count, 0);
    check("midrst_cnt4", t4_retire_count, 0);
    reset = 1'b1;

    // Seventeen retirements wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++)
      drive(1, 1, 5'd22, WB_SEL_ALU, 32'(i), 32'h0, 32'h0, LT_LW, 2'd0);
    check("wrap_cnt4", t4_retire_count, 1);
    check("wrap_cnt32", retire_count, exp_cnt);
    check("wrap_cnt17", retire_count, 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the pipelined processor. It latches the MEM/WB pipeline register, selects the result, and aligns and sign-extends load data.
- Drives the register file write port: writeReg, writeEnable and writeData.
- Exports a forwarding tap for the hazard/forwarding unit and a retired-instruction counter.
- Registers on posedge clk. The register file commits on the following negedge, so decode reads see the value in the same cycle.

Parameters:
- DATA_W, 32, datapath width
- REG_ADDR_W, 5, register index width
- CNT_W, 32, retire counter width

Ports:
- clk  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  MEM stage presents an instruction
- stall  input  1  hold current WB contents
- flush  input  1  replace WB contents with a bubble
- in_reg_write  input  1  instruction writes rd
- in_rd  input  REG_ADDR_W  destination register
- in_wb_sel  input  2  result source: ALU, MEM or LINK
- in_alu_result  input  DATA_W  ALU result
- in_mem_data  input  DATA_W  raw aligned word from data memory
- in_pc_plus4  input  DATA_W  link value
- in_load_type  input  3  load type: LB, LH, LW, LBU or LHU
- in_byte_off  input  2  address bits [1:0] of the load
- writeReg  output  REG_ADDR_W  register file write index
- writeEnable  output  1  register file write strobe
- writeData  output  DATA_W  register file write data
- wb_valid  output  1  WB holds a valid instruction
- fwd_en  output  1  forwarding tap is valid (equals writeEnable)
- fwd_rd  output  REG_ADDR_W  forwarding register index (equals writeReg)
- fwd_data  output  DATA_W  forwarding data (equals writeData)
- misalign_err  output  1  latched load is misaligned
- retire_count  output  CNT_W  retired-instruction count

Behaviour:
- Reset (reset==0 at posedge):
  - all latched fields cleared; wb_valid=0, writeEnable=0, writeReg=0, writeData=0, misalign_err=0, retire_count=0.
  - Reset overrides flush and stall.
  - Reset asserted mid-operation discards the latched instruction; no write occurs that cycle.
- Update priority at posedge when reset==1: flush, then stall, then capture.
  - flush: wb_valid<=0; other fields don't-care, and outputs must still show writeEnable=0.
  - stall (no flush): all latched fields hold. writeEnable stays asserted, so the same value is rewritten, which is idempotent.
  - otherwise: latch all in_* fields; wb_valid<=in_valid.
- Latency: one cycle from the MEM-stage inputs to the write-port outputs. writeData and writeReg are combinational from the latched fields.
- Result select:
  - ALU: alu_result.
  - LINK: pc_plus4.
  - MEM: load_extend output.
  - wb_sel=11 is reserved: writeData=0 and writeEnable=0.
- Load extend (MEM only):
  - LB/LBU: byte [8*off+7:8*off], sign- or zero-extended.
  - LH/LHU: half at off[1]; off[0] must be 0.
  - LW: off must be 00.
- Misalignment:
  - misalign_err=wb_valid & wb_sel==MEM & misaligned; it is combinational and asserted while the entry is held.
  - A misaligned load forces writeEnable=0.
- writeEnable = wb_valid & reg_write & (rd!=0) & !misalign_err & wb_sel!=11.
  - rd==0 never asserts writeEnable; writeData is don't-care.
- retire_count:
  - +1 at a posedge where a capture occurs with in_valid=1 (no reset, no flush, no stall).
  - Misaligned loads still count.
  - Wraps modulo 2^CNT_W with no saturation.
- Simultaneous stall+flush: flush wins and the count does not increment.
- Back-to-back writes to the same rd: each cycle's value is presented; the last one wins in the register file.

Decomposition:
- Package wb_pkg holds:
  - WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_LINK=2'b10
  - LT_LB=3'd0, LT_LH=3'd1, LT_LW=3'd2, LT_LBU=3'd4, LT_LHU=3'd5
  - DATA_W and REG_ADDR_W defaults
- Sub-module load_extend: combinational; inputs raw word, load_type and byte_off; outputs extended data and misaligned.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1, rd=5 -> writeEnable=0, retire_count=0, all outputs 0 after the first posedge.
- ALU write: in_valid=1, reg_write=1, rd=7, ALU, alu_result=0xDEADBEEF -> next cycle writeReg=7, writeEnable=1, writeData=0xDEADBEEF, fwd_* identical; register file reads 0xDEADBEEF from reg 7 in that same cycle; retire_count=1.
- Loads with mem_data=0x80FF7F01:
  - LB off=3 -> 0xFFFFFF80
  - LBU off=3 -> 0x00000080
  - LH off=2 -> 0xFFFF80FF
  - LHU off=0 -> 0x00007F01
  - LW off=0 -> 0x80FF7F01
  - LH off=1 -> misalign_err=1, writeEnable=0
- Boundary: rd=0 with reg_write=1 -> writeEnable=0; LINK with pc_plus4=0x00000104 and rd=31 -> writeData=0x00000104; wb_sel=11 -> writeEnable=0.
- Stall/flush: capture rd=3, then stall 3 cycles -> outputs held, count unchanged; stall+flush together -> wb_valid=0, writeEnable=0, count unchanged.
- Wrap: CNT_W=4, retire 17 instructions -> retire_count=1.
